// File: rtl/uart_pkg.sv
// Shared UART transmit types and constants: FSM state encoding, line levels, parity selectors.
// Imported by the framer top and its bit timer.
package uart_pkg;

  localparam int PRESCALE_W = 6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// Bit timer: edge counter 0..P-1 (P = max(prescale,1)) and 4-bit bit index; bit_tick on the last edge of a bit.
// Latency: bit_tick is combinational from the counter; no backpressure, counts only while enabled.
module tx_bit_timer
  import uart_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_tick,
  output logic [3:0]            bit_idx
);

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] edge_last;

  // A prescale of 0 behaves like 1: every edge is the last edge of a bit.
  assign edge_last = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
  assign bit_tick  = enable && (edge_cnt == edge_last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
    end else if (enable) begin
      if (bit_tick) begin
        edge_cnt <= '0;
        bit_idx  <= bit_idx + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX framer: start, DATA_WIDTH bits LSB first, optional parity (UART_TX_PARITY_EN), one stop; P cycles per bit.
// Latency: start bit on the line one edge after Data_Valid is accepted; Data_Valid while busy is dropped (no queueing).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  uart_tx_state_e        state;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  accept;
  logic                  bit_tick;
  logic [3:0]            bit_idx;
  logic                  last_data;
  logic                  state_chg;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_par;
  assign unused_par = ^{PAR_EN, PAR_TYP};
`endif

  assign accept    = Data_Valid && !busy;
  assign last_data = (bit_idx == 4'(DATA_WIDTH - 1));
  // The bit counter restarts whenever the FSM leaves a state, including on acceptance.
  assign state_chg = accept || (bit_tick && ((state != DATA) || last_data));

  tx_bit_timer u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (busy),
    .clear    (state_chg),
    .prescale (pre_q),
    .bit_tick (bit_tick),
    .bit_idx  (bit_idx)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      TX_OUT  <= STOP_BIT;
      busy    <= 1'b0;
      data_sh <= '0;
      pre_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (accept) begin
      state   <= START;
      TX_OUT  <= START_BIT;
      busy    <= 1'b1;
      data_sh <= P_DATA;
      pre_q   <= prescale;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= PAR_EN;
      par_bit_q <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
`endif
    end else if (bit_tick) begin
      unique case (state)
        START: begin
          state   <= DATA;
          TX_OUT  <= data_sh[0];
          data_sh <= data_sh >> 1;
        end
        DATA: begin
          if (last_data) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= STOP;
              TX_OUT <= STOP_BIT;
            end
`else
            state  <= STOP;
            TX_OUT <= STOP_BIT;
`endif
          end else begin
            TX_OUT  <= data_sh[0];
            data_sh <= data_sh >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
        end
`endif
        STOP: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= STOP_BIT;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
